// File: rtl/car_cmd_decoder_if.sv
// Decoded car command bundle.
// The decoder drives it through the master modport and consumers read it through the slave modport.
interface car_cmd_if;
   logic [3:0] moving_state;
   logic       place_barrier;
   logic       destroy_barrier;
   logic       cmd_valid;
   logic       frame_err;
   logic       link_alive;

   modport master (
      output moving_state,
      output place_barrier,
      output destroy_barrier,
      output cmd_valid,
      output frame_err,
      output link_alive
   );

   modport slave (
      input moving_state,
      input place_barrier,
      input destroy_barrier,
      input cmd_valid,
      input frame_err,
      input link_alive
   );
endinterface

// File: rtl/car_cmd_decoder.sv
// UART 8N1 receiver for the car command byte {2'b10, destroy, place, moving_state[3:0]}.
// Rejects frames with a bad header or a bad stop bit.
// Emits one-cycle request pulses on rising barrier bits.
// A link watchdog forces a safe stop when valid frames stop arriving.
module car_cmd_decoder #(
   parameter int CLKS_PER_BIT   = 10416,
   parameter int TIMEOUT_CYCLES = 10_000_000
) (
   input  logic      sys_clk,
   input  logic      rst,
   input  logic      rx,
   car_cmd_if.master cmd
);

   localparam int CW = $clog2(CLKS_PER_BIT + 1);
   localparam int WW = $clog2(TIMEOUT_CYCLES + 1);

   localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
   localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
   localparam logic [CW-1:0] CYC_ONE   = CW'(1);
   localparam logic [WW-1:0] WD_LAST   = WW'(TIMEOUT_CYCLES - 1);
   localparam logic [WW-1:0] WD_MAX    = WW'(TIMEOUT_CYCLES);
   localparam logic [WW-1:0] WD_ONE    = WW'(1);

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      START = 3'd1,
      DATA  = 3'd2,
      STOP  = 3'd3,
      BREAK = 3'd4
   } state_t;

   state_t          state;
   logic            rx_meta;
   logic            rx_s;
   logic [CW-1:0]   cyc_cnt;
   logic [2:0]      bit_cnt;
   logic [7:0]      shift;
   logic            prev4;
   logic            prev5;
   logic [WW-1:0]   wdog;
   logic            stop_sample;
   logic            accept;
   logic            reject;

   // Only frames tagged 2'b10 in the top two bits are car commands.
   function automatic logic header_ok(input logic [1:0] hdr);
      return (hdr == 2'b10);
   endfunction

   // Two-flop synchroniser for the asynchronous serial line; idles high.
   always_ff @(posedge sys_clk) begin
      if (rst) begin
         rx_meta <= 1'b1;
         rx_s    <= 1'b1;
      end else begin
         rx_meta <= rx;
         rx_s    <= rx_meta;
      end
   end

   // Classify the stop-bit sample as an accepted or a rejected frame.
   always_comb begin
      stop_sample = 1'b0;
      accept      = 1'b0;
      reject      = 1'b0;
      if (state == STOP && cyc_cnt == BIT_LAST) begin
         stop_sample = 1'b1;
         accept      = rx_s & header_ok(shift[7:6]);
         reject      = ~(rx_s & header_ok(shift[7:6]));
      end else begin
         stop_sample = 1'b0;
      end
   end

   // Receive FSM, registered command outputs and link watchdog.
   always_ff @(posedge sys_clk) begin
      if (rst) begin
         state               <= IDLE;
         cyc_cnt             <= '0;
         bit_cnt             <= 3'd0;
         shift               <= 8'h00;
         prev4               <= 1'b0;
         prev5               <= 1'b0;
         wdog                <= '0;
         cmd.moving_state    <= 4'd0;
         cmd.place_barrier   <= 1'b0;
         cmd.destroy_barrier <= 1'b0;
         cmd.cmd_valid       <= 1'b0;
         cmd.frame_err       <= 1'b0;
         cmd.link_alive      <= 1'b0;
      end else begin
         cmd.place_barrier   <= 1'b0;
         cmd.destroy_barrier <= 1'b0;
         cmd.cmd_valid       <= 1'b0;
         cmd.frame_err       <= 1'b0;

         case (state)
            IDLE: begin
               if (!rx_s) begin
                  state   <= START;
                  cyc_cnt <= '0;
               end
            end
            START: begin
               // Re-check at mid start bit so that short glitches are dropped.
               if (cyc_cnt == HALF_LAST) begin
                  cyc_cnt <= '0;
                  bit_cnt <= 3'd0;
                  state   <= rx_s ? IDLE : DATA;
               end else begin
                  cyc_cnt <= cyc_cnt + CYC_ONE;
               end
            end
            DATA: begin
               if (cyc_cnt == BIT_LAST) begin
                  cyc_cnt        <= '0;
                  shift[bit_cnt] <= rx_s;
                  if (bit_cnt == 3'd7) begin
                     state <= STOP;
                  end else begin
                     bit_cnt <= bit_cnt + 3'd1;
                  end
               end else begin
                  cyc_cnt <= cyc_cnt + CYC_ONE;
               end
            end
            STOP: begin
               if (stop_sample) begin
                  cyc_cnt       <= '0;
                  cmd.frame_err <= reject;
                  // A low stop bit means a line break: wait for the line to go high again.
                  state         <= rx_s ? IDLE : BREAK;
               end else begin
                  cyc_cnt <= cyc_cnt + CYC_ONE;
               end
            end
            BREAK: begin
               if (rx_s) begin
                  state <= IDLE;
               end
            end
            default: begin
               state   <= IDLE;
               cyc_cnt <= '0;
               bit_cnt <= 3'd0;
            end
         endcase

         // An accept on the timeout cycle takes priority over the forced stop.
         if (accept) begin
            cmd.moving_state    <= shift[3:0];
            cmd.cmd_valid       <= 1'b1;
            cmd.link_alive      <= 1'b1;
            cmd.place_barrier   <= shift[4] & ~prev4;
            cmd.destroy_barrier <= shift[5] & ~prev5;
            prev4               <= shift[4];
            prev5               <= shift[5];
            wdog                <= '0;
         end else if (wdog == WD_LAST) begin
            wdog             <= WD_MAX;
            cmd.moving_state <= 4'd0;
            cmd.link_alive   <= 1'b0;
            prev4            <= 1'b0;
            prev5            <= 1'b0;
         end else if (wdog != WD_MAX) begin
            wdog <= wdog + WD_ONE;
         end
      end
   end

endmodule

// File: tb/tb_car_cmd_decoder.sv
// Directed bench for car_cmd_decoder with 16 clocks per bit and a 2000-cycle link timeout.
module tb_car_cmd_decoder;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic rx  = 1'b1;

   int checks   = 0;
   int failures = 0;

   // Pulse monitor state: written only by the monitor process.
   int   cyc_n  = 0;
   int   cv_n   = 0;
   int   fe_n   = 0;
   int   pl_n   = 0;
   int   de_n   = 0;
   int   both_n = 0;
   int   wide_n = 0;
   int   last_cv_cyc = 0;
   logic prev_cv = 1'b0;
   logic prev_fe = 1'b0;
   logic prev_pl = 1'b0;
   logic prev_de = 1'b0;

   always #5 clk = ~clk;

   car_cmd_if cmd ();

   car_cmd_decoder #(
      .CLKS_PER_BIT   (16),
      .TIMEOUT_CYCLES (2000)
   ) dut (
      .sys_clk (clk),
      .rst     (rst),
      .rx      (rx),
      .cmd     (cmd)
   );

   // Count pulses, overlapping pulses and pulses wider than one cycle.
   always @(negedge clk) begin
      cyc_n <= cyc_n + 1;
      if (cmd.cmd_valid) begin
         cv_n        <= cv_n + 1;
         last_cv_cyc <= cyc_n;
      end
      if (cmd.frame_err)       fe_n <= fe_n + 1;
      if (cmd.place_barrier)   pl_n <= pl_n + 1;
      if (cmd.destroy_barrier) de_n <= de_n + 1;
      if (cmd.cmd_valid && cmd.frame_err) both_n <= both_n + 1;
      if ((cmd.cmd_valid && prev_cv) || (cmd.frame_err && prev_fe) ||
          (cmd.place_barrier && prev_pl) || (cmd.destroy_barrier && prev_de))
         wide_n <= wide_n + 1;
      prev_cv <= cmd.cmd_valid;
      prev_fe <= cmd.frame_err;
      prev_pl <= cmd.place_barrier;
      prev_de <= cmd.destroy_barrier;
   end

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   // One 8N1 frame; a low stop bit can be followed by a further low hold of low_bits bit times.
   task automatic send_frame(input logic [7:0] b, input logic stop, input int low_bits);
      tick(1);
      rx = 1'b0;
      tick(16);
      for (int i = 0; i < 8; i++) begin
         rx = b[i];
         tick(16);
      end
      rx = stop;
      tick(16);
      if (low_bits > 0) begin
         rx = 1'b0;
         tick(16 * low_bits);
      end
      rx = 1'b1;
      tick(24);
   endtask

   task automatic test_reset;
      checks++;
      if (cmd.moving_state !== 4'd0) begin
         failures++;
         $display("FAIL reset_moving_state got=%h exp=0", cmd.moving_state);
      end
      checks++;
      if ({cmd.place_barrier, cmd.destroy_barrier, cmd.cmd_valid, cmd.frame_err, cmd.link_alive} !== 5'b00000) begin
         failures++;
         $display("FAIL reset_flags got=%b exp=00000",
                  {cmd.place_barrier, cmd.destroy_barrier, cmd.cmd_valid, cmd.frame_err, cmd.link_alive});
      end
   endtask

   task automatic test_single;
      int cv0 = cv_n, pl0 = pl_n, de0 = de_n;
      send_frame(8'h85, 1'b1, 0);
      checks++;
      if (cv_n - cv0 !== 1) begin
         failures++;
         $display("FAIL single_cmd_valid got=%0d exp=1", cv_n - cv0);
      end
      checks++;
      if (cmd.moving_state !== 4'b0101) begin
         failures++;
         $display("FAIL single_moving_state got=%b exp=0101", cmd.moving_state);
      end
      checks++;
      if (cmd.link_alive !== 1'b1) begin
         failures++;
         $display("FAIL single_link_alive got=%b exp=1", cmd.link_alive);
      end
      checks++;
      if ((pl_n - pl0) + (de_n - de0) !== 0) begin
         failures++;
         $display("FAIL single_barrier got=%0d exp=0", (pl_n - pl0) + (de_n - de0));
      end
   endtask

   task automatic test_place;
      logic [7:0] seq [4];
      int         exp_pl [4];
      seq[0] = 8'h95; seq[1] = 8'h95; seq[2] = 8'h85; seq[3] = 8'h95;
      exp_pl[0] = 1;  exp_pl[1] = 0;  exp_pl[2] = 0;  exp_pl[3] = 1;
      for (int k = 0; k < 4; k++) begin
         int pl0 = pl_n;
         send_frame(seq[k], 1'b1, 0);
         checks++;
         if (pl_n - pl0 !== exp_pl[k]) begin
            failures++;
            $display("FAIL place_frame%0d got=%0d exp=%0d", k, pl_n - pl0, exp_pl[k]);
         end
         checks++;
         if (cmd.moving_state !== 4'b0101) begin
            failures++;
            $display("FAIL place_moving_state%0d got=%b exp=0101", k, cmd.moving_state);
         end
      end
   endtask

   task automatic test_destroy;
      int pl0 = pl_n, de0 = de_n;
      send_frame(8'hA5, 1'b1, 0);
      checks++;
      if ({pl_n - pl0, de_n - de0} !== {32'd0, 32'd1}) begin
         failures++;
         $display("FAIL destroy_A5 got place=%0d destroy=%0d exp place=0 destroy=1", pl_n - pl0, de_n - de0);
      end
      pl0 = pl_n;
      de0 = de_n;
      send_frame(8'hB5, 1'b1, 0);
      checks++;
      if ({pl_n - pl0, de_n - de0} !== {32'd1, 32'd0}) begin
         failures++;
         $display("FAIL destroy_B5 got place=%0d destroy=%0d exp place=1 destroy=0", pl_n - pl0, de_n - de0);
      end
   endtask

   task automatic test_reject;
      int cv0 = cv_n, fe0 = fe_n, pl0 = pl_n;
      send_frame(8'h45, 1'b1, 0);
      send_frame(8'h82, 1'b0, 0);
      checks++;
      if (fe_n - fe0 !== 2) begin
         failures++;
         $display("FAIL reject_frame_err got=%0d exp=2", fe_n - fe0);
      end
      checks++;
      if (cv_n - cv0 !== 0) begin
         failures++;
         $display("FAIL reject_cmd_valid got=%0d exp=0", cv_n - cv0);
      end
      checks++;
      if (cmd.moving_state !== 4'b0101) begin
         failures++;
         $display("FAIL reject_moving_state got=%b exp=0101", cmd.moving_state);
      end
      checks++;
      if (pl_n - pl0 !== 0) begin
         failures++;
         $display("FAIL reject_place got=%0d exp=0", pl_n - pl0);
      end
   endtask

   task automatic test_break;
      int cv0 = cv_n, fe0 = fe_n;
      send_frame(8'h85, 1'b0, 100);
      checks++;
      if (fe_n - fe0 !== 1) begin
         failures++;
         $display("FAIL break_frame_err got=%0d exp=1", fe_n - fe0);
      end
      checks++;
      if (cv_n - cv0 !== 0) begin
         failures++;
         $display("FAIL break_cmd_valid got=%0d exp=0", cv_n - cv0);
      end
      cv0 = cv_n;
      send_frame(8'h8A, 1'b1, 0);
      checks++;
      if (cv_n - cv0 !== 1) begin
         failures++;
         $display("FAIL break_recover_valid got=%0d exp=1", cv_n - cv0);
      end
      checks++;
      if (cmd.moving_state !== 4'b1010) begin
         failures++;
         $display("FAIL break_recover_state got=%b exp=1010", cmd.moving_state);
      end
   endtask

   task automatic test_glitch;
      int cv0 = cv_n, fe0 = fe_n;
      tick(1);
      rx = 1'b0;
      tick(4);
      rx = 1'b1;
      tick(40);
      checks++;
      if ((cv_n - cv0) + (fe_n - fe0) !== 0) begin
         failures++;
         $display("FAIL glitch_pulses got cv=%0d fe=%0d exp 0 0", cv_n - cv0, fe_n - fe0);
      end
      cv0 = cv_n;
      send_frame(8'h83, 1'b1, 0);
      checks++;
      if (cv_n - cv0 !== 1 || cmd.moving_state !== 4'b0011) begin
         failures++;
         $display("FAIL glitch_next_frame got cv=%0d state=%b exp cv=1 state=0011", cv_n - cv0, cmd.moving_state);
      end
   endtask

   task automatic test_timeout_rst;
      logic [7:0] b;
      int         cv0, fe0, pl0, de0;
      send_frame(8'h8F, 1'b1, 0);
      checks++;
      if (cmd.moving_state !== 4'hF || cmd.link_alive !== 1'b1) begin
         failures++;
         $display("FAIL timeout_accept got state=%h alive=%b exp state=f alive=1", cmd.moving_state, cmd.link_alive);
      end
      // Just before the timeout the link must still be alive.
      tick(last_cv_cyc + 1995 - cyc_n);
      checks++;
      if (cmd.link_alive !== 1'b1 || cmd.moving_state !== 4'hF) begin
         failures++;
         $display("FAIL timeout_early got state=%h alive=%b exp state=f alive=1", cmd.moving_state, cmd.link_alive);
      end
      tick(10);
      checks++;
      if (cmd.link_alive !== 1'b0 || cmd.moving_state !== 4'd0) begin
         failures++;
         $display("FAIL timeout_expired got state=%h alive=%b exp state=0 alive=0", cmd.moving_state, cmd.link_alive);
      end
      // Reset in the middle of the next byte.
      cv0 = cv_n; fe0 = fe_n; pl0 = pl_n; de0 = de_n;
      b = 8'h95;
      rx = 1'b0;
      tick(16);
      for (int i = 0; i < 5; i++) begin
         rx = b[i];
         tick(16);
      end
      rst = 1'b1;
      tick(3);
      checks++;
      if ({cmd.moving_state, cmd.place_barrier, cmd.destroy_barrier, cmd.cmd_valid, cmd.frame_err, cmd.link_alive} !== 9'd0) begin
         failures++;
         $display("FAIL rst_mid_outputs got state=%h flags=%b exp all zero", cmd.moving_state,
                  {cmd.place_barrier, cmd.destroy_barrier, cmd.cmd_valid, cmd.frame_err, cmd.link_alive});
      end
      rx = 1'b1;
      tick(2);
      rst = 1'b0;
      tick(40);
      checks++;
      if ((cv_n - cv0) + (fe_n - fe0) + (pl_n - pl0) + (de_n - de0) !== 0) begin
         failures++;
         $display("FAIL rst_mid_pulses got cv=%0d fe=%0d pl=%0d de=%0d exp all zero",
                  cv_n - cv0, fe_n - fe0, pl_n - pl0, de_n - de0);
      end
      cv0 = cv_n;
      send_frame(8'h81, 1'b1, 0);
      checks++;
      if (cv_n - cv0 !== 1 || cmd.moving_state !== 4'b0001 || cmd.link_alive !== 1'b1) begin
         failures++;
         $display("FAIL rst_recover got cv=%0d state=%b alive=%b exp cv=1 state=0001 alive=1",
                  cv_n - cv0, cmd.moving_state, cmd.link_alive);
      end
   endtask

   task automatic test_pulse_rules;
      checks++;
      if (both_n !== 0) begin
         failures++;
         $display("FAIL pulse_exclusive got=%0d exp=0", both_n);
      end
      checks++;
      if (wide_n !== 0) begin
         failures++;
         $display("FAIL pulse_width got=%0d exp=0", wide_n);
      end
   endtask

   initial begin
      rst = 1'b1;
      rx  = 1'b1;
      tick(5);
      test_reset();
      rst = 1'b0;
      tick(10);
      test_single();
      test_place();
      test_destroy();
      test_reject();
      test_break();
      test_glitch();
      test_timeout_rst();
      test_pulse_rules();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
